// File: rtl/magma_pkg.sv
// Shared Magma (GOST 28147-89) constants: S-box, FSM states and round-key helpers.
// Used by both the encryption and decryption blocks.
package magma_pkg;

  localparam int unsigned ROUNDS = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Row j substitutes nibble j; entry k is the k-th hex digit from the left (packed index 15-k).
  localparam logic [15:0][3:0] SBOX [8] = '{
    64'hC462A5B9E8D703F1,
    64'h68239A5C1E47BD0F,
    64'hB3582FADE174C960,
    64'hC821D4F670A53E9B,
    64'h7F5A816D093EB42C,
    64'h5DF692CAB78143E0,
    64'h8E25691CF4B0DA37,
    64'h17ED05834FA69CB2
  };

  function automatic logic [31:0] sbox_sub(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int j = 0; j < 8; j++) begin
      y[4*j +: 4] = SBOX[j][~x[4*j +: 4]];
    end
    return y;
  endfunction

  // Key word index for a round: ascending for rounds 0..23, descending for 24..31.
  function automatic logic [2:0] key_idx(input logic [4:0] rnd);
    return (rnd < 5'd24) ? rnd[2:0] : ~rnd[2:0];
  endfunction

endpackage

// File: rtl/magma_round.sv
// One Magma Feistel round; the final round omits the half swap.
module magma_round
  import magma_pkg::*;
(
  input  logic [31:0] a1_i,
  input  logic [31:0] a0_i,
  input  logic [31:0] k_i,
  input  logic        last_i,
  output logic [31:0] a1_o,
  output logic [31:0] a0_o
);

  logic [31:0] sum;
  logic [31:0] sub;
  logic [31:0] g_out;

  assign sum   = a0_i + k_i;
  assign sub   = sbox_sub(sum);
  assign g_out = {sub[20:0], sub[31:21]};

  assign a1_o = last_i ? (a1_i ^ g_out) : a0_i;
  assign a0_o = last_i ? a0_i : (a1_i ^ g_out);

endmodule

// File: rtl/magma_encrypt.sv
// Iterative Magma block encryptor: UNROLL rounds per RUN cycle, 32/UNROLL RUN cycles per block.
// UNROLL must be 1, 2, 4 or 8.
module magma_encrypt
  import magma_pkg::*;
#(
  parameter int unsigned UNROLL = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [63:0]   plaintext,
  input  logic [255:0]  key,
  output logic [63:0]   ciphertext,
  output logic          busy,
  output logic          done
);

  state_e           state_q, state_d;
  logic [4:0]       r_q, r_d;
  logic [31:0]      a1_q, a1_d;
  logic [31:0]      a0_q, a0_d;
  logic [7:0][31:0] key_q, key_d;
  logic [63:0]      ct_q, ct_d;

  logic             accept;
  logic             last_cycle;
  logic [31:0]      a1_c [UNROLL+1];
  logic [31:0]      a0_c [UNROLL+1];

  assign accept     = start && ((state_q == StIdle) || (state_q == StDone));
  assign last_cycle = (r_q == 5'(ROUNDS - UNROLL));

  assign a1_c[0] = a1_q;
  assign a0_c[0] = a0_q;

  // key_q[7] holds K[0] (the top key word), so K[i] is key_q[7-i].
  for (genvar u = 0; u < UNROLL; u++) begin : g_round
    logic [4:0] rnd;
    assign rnd = r_q + 5'(u);

    magma_round u_round (
      .a1_i   (a1_c[u]),
      .a0_i   (a0_c[u]),
      .k_i    (key_q[3'd7 - key_idx(rnd)]),
      .last_i (rnd == 5'(ROUNDS - 1)),
      .a1_o   (a1_c[u+1]),
      .a0_o   (a0_c[u+1])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_cycle) state_d = StDone;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    r_d   = r_q;
    a1_d  = a1_q;
    a0_d  = a0_q;
    key_d = key_q;
    ct_d  = ct_q;
    if (accept) begin
      r_d   = '0;
      a1_d  = plaintext[63:32];
      a0_d  = plaintext[31:0];
      key_d = key;
    end else if (state_q == StRun) begin
      r_d  = r_q + 5'(UNROLL);
      a1_d = a1_c[UNROLL];
      a0_d = a0_c[UNROLL];
      if (last_cycle) ct_d = {a1_c[UNROLL], a0_c[UNROLL]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      r_q     <= '0;
      a1_q    <= '0;
      a0_q    <= '0;
      key_q   <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      a1_q    <= a1_d;
      a0_q    <= a0_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
    end
  end

  assign busy       = (state_q == StRun);
  assign done       = (state_q == StDone);
  assign ciphertext = ct_q;

endmodule

// File: tb/tb_magma_encrypt.sv
// Scoreboard bench for magma_encrypt: UNROLL=1 and UNROLL=4 instances, known-answer and model vectors.
module tb_magma_encrypt;

  localparam logic [255:0] STD_KEY =
    256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [63:0]  STD_PT = 64'hfedcba9876543210;
  localparam logic [63:0]  STD_CT = 64'h4ee901e5c2d8ca3d;
  localparam int           LAT1   = 32;
  localparam int           LAT4   = 8;

  localparam logic [63:0] TB_SBOX [8] = '{
    64'hC462A5B9E8D703F1, 64'h68239A5C1E47BD0F, 64'hB3582FADE174C960, 64'hC821D4F670A53E9B,
    64'h7F5A816D093EB42C, 64'h5DF692CAB78143E0, 64'h8E25691CF4B0DA37, 64'h17ED05834FA69CB2
  };

  typedef struct {
    logic [63:0] ct;
    int          due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         start4;
  logic [63:0]  pt;
  logic [255:0] key;
  logic [63:0]  ct1, ct4;
  logic         busy1, busy4, done1, done4;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   busy_run1 = 0;
  int   busy_run4 = 0;
  int   done_cnt1 = 0;
  exp_t q1[$];
  exp_t q4[$];

  magma_encrypt #(.UNROLL(1)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .plaintext  (pt),
    .key        (key),
    .ciphertext (ct1),
    .busy       (busy1),
    .done       (done1)
  );

  magma_encrypt #(.UNROLL(4)) u_dut4 (
    .clk        (clk),
    .rst        (rst),
    .start      (start4),
    .plaintext  (pt),
    .key        (key),
    .ciphertext (ct4),
    .busy       (busy4),
    .done       (done4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Plain round-by-round reference, written independently of the RTL chain.
  function automatic logic [63:0] ref_enc(input logic [63:0] p, input logic [255:0] k);
    logic [31:0] a1, a0, t, s, kr, tmp;
    int          ki;
    a1 = p[63:32];
    a0 = p[31:0];
    for (int r = 0; r < 32; r++) begin
      ki = (r < 24) ? (r % 8) : (7 - (r % 8));
      kr = k[255 - 32*ki -: 32];
      t  = a0 + kr;
      for (int j = 0; j < 8; j++) s[4*j +: 4] = TB_SBOX[j][63 - 4*int'(t[4*j +: 4]) -: 4];
      s = {s[20:0], s[31:21]};
      if (r == 31) a1 = a1 ^ s;
      else begin
        tmp = a0;
        a0  = a1 ^ s;
        a1  = tmp;
      end
    end
    return {a1, a0};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_run1 = 0;
      busy_run4 = 0;
    end else begin
      check_eq("busy_done_excl1", 64'(busy1 & done1), 64'd0);
      check_eq("busy_done_excl4", 64'(busy4 & done4), 64'd0);
      if (busy1) busy_run1++;
      if (busy4) busy_run4++;
      if (done1) begin
        done_cnt1++;
        if (q1.size() == 0) check_eq("unexpected_done1", 64'd1, 64'd0);
        else begin
          e = q1.pop_front();
          check_eq("ct1", ct1, e.ct);
          check_eq("latency1", 64'(cyc), 64'(e.due));
          check_eq("busy_cycles1", 64'(busy_run1), 64'(LAT1));
        end
        busy_run1 = 0;
      end
      if (done4) begin
        if (q4.size() == 0) check_eq("unexpected_done4", 64'd1, 64'd0);
        else begin
          e = q4.pop_front();
          check_eq("ct4", ct4, e.ct);
          check_eq("latency4", 64'(cyc), 64'(e.due));
          check_eq("busy_cycles4", 64'(busy_run4), 64'(LAT4));
        end
        busy_run4 = 0;
      end
    end
  end

  task automatic launch1(input logic [63:0] p, input logic [255:0] k, input logic [63:0] e);
    @(negedge clk);
    pt    = p;
    key   = k;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    q1.push_back('{e, cyc + LAT1});
  endtask

  task automatic launch4(input logic [63:0] p, input logic [255:0] k, input logic [63:0] e);
    @(negedge clk);
    pt     = p;
    key    = k;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    q4.push_back('{e, cyc + LAT4});
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q1.size() != 0 || q4.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_timeout", 64'(q1.size() + q4.size()), 64'd0);
    q1.delete();
    q4.delete();
  endtask

  initial begin
    logic [63:0]  rp, re;
    logic [255:0] rk;
    int           c0, done_before;

    rst    = 1'b1;
    start  = 1'b0;
    start4 = 1'b0;
    pt     = '0;
    key    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy1", 64'(busy1), 64'd0);
    check_eq("rst_done1", 64'(done1), 64'd0);
    check_eq("rst_ct1", ct1, 64'd0);
    check_eq("rst_ct4", ct4, 64'd0);
    rst = 1'b0;

    // Known-answer vector on both unroll factors, then result must hold in IDLE.
    launch1(STD_PT, STD_KEY, STD_CT);
    drain(100);
    repeat (3) @(negedge clk);
    check_eq("ct1_hold", ct1, STD_CT);
    launch4(STD_PT, STD_KEY, STD_CT);
    drain(100);
    repeat (3) @(negedge clk);
    check_eq("ct4_hold", ct4, STD_CT);

    // Start pulse during RUN cycle 10 with another block must be ignored.
    launch1(STD_PT, STD_KEY, STD_CT);
    repeat (10) @(negedge clk);
    pt    = 64'h0123456789abcdef;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain(100);

    // Inputs overwritten one cycle after the accepting edge.
    launch1(STD_PT, STD_KEY, STD_CT);
    @(negedge clk);
    pt  = '1;
    key = '1;
    drain(100);

    // Start held through DONE: second block begins with no idle cycle.
    @(negedge clk);
    pt    = STD_PT;
    key   = STD_KEY;
    start = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    q1.push_back('{STD_CT, c0 + LAT1});
    q1.push_back('{STD_CT, c0 + 2*LAT1 + 1});
    repeat (LAT1 + 1) @(posedge clk);
    #1;
    start = 1'b0;
    drain(100);

    // Random vectors against the reference model.
    for (int i = 0; i < 3; i++) begin
      rp = {$urandom, $urandom};
      for (int j = 0; j < 8; j++) rk[32*j +: 32] = $urandom;
      re = ref_enc(rp, rk);
      launch1(rp, rk, re);
      launch4(rp, rk, re);
      drain(100);
    end

    // Reset in RUN cycle 15 aborts the block.
    launch1(STD_PT, STD_KEY, STD_CT);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q1.delete();
    check_eq("abort_busy", 64'(busy1), 64'd0);
    check_eq("abort_done", 64'(done1), 64'd0);
    check_eq("abort_ct", ct1, 64'd0);
    done_before = done_cnt1;
    repeat (40) @(negedge clk);
    check_eq("no_done_after_rst", 64'(done_cnt1), 64'(done_before));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
